reg_swap_sched: RTL

REG_SWAP_SCHED -- requirements
Module: reg_swap_sched

---
 rtl/reg_swap_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/reg_swap_sched.sv | 116 +++++++++++
 3 files changed

// File: rtl/reg_swap_pkg.sv
// Shared definitions for reg_swap_sched: opcode encodings and FSM state type.
// With SWAP_XOR_EN defined, the state type gains the XOR1/XOR2 steps.
package reg_swap_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD_A = 2'b01;
  localparam logic [1:0] OP_LOAD_B = 2'b10;
  localparam logic [1:0] OP_SWAP   = 2'b11;

`ifdef SWAP_XOR_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_ACK  = 3'd2,
    ST_XOR1 = 3'd3,
    ST_XOR2 = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts just after the last
// granted index and wraps, giving a one-hot winner and its index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          valid
);

  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    // k = N revisits the last winner itself, so it is the lowest priority
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!valid && req[IW'(idx)]) begin
        valid            = 1'b1;
        win[IW'(idx)]    = 1'b1;
        win_idx          = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_swap_sched.sv
// Round-robin scheduler granting N requesters access to shared registers A/B.
// Define SWAP_XOR_EN to run SWAP as three in-place XOR steps instead of one.
module reg_swap_sched
  import reg_swap_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] op,
  input  logic [W*N-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic           ack,
  output logic           busy,
  output logic [W-1:0]   a_q,
  output logic [W-1:0]   b_q
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t        state_reg, state_next;
  logic [N-1:0]  gnt_reg;
  logic [1:0]    op_reg;
  logic [W-1:0]  data_reg;
  logic [IW-1:0] last_reg;

  logic [1:0]    op_sel    [N];
  logic [W-1:0]  wdata_sel [N];
  logic [N-1:0]  win_onehot;
  logic [IW-1:0] win_idx;
  logic          win_valid;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_split
      assign op_sel[gi]    = op[2*gi +: 2];
      assign wdata_sel[gi] = wdata[W*gi +: W];
    end
  endgenerate

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req     (req),
    .last    (last_reg),
    .win     (win_onehot),
    .win_idx (win_idx),
    .valid   (win_valid)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (win_valid) state_next = ST_EXEC;
`ifdef SWAP_XOR_EN
      ST_EXEC: state_next = (op_reg == OP_SWAP) ? ST_XOR1 : ST_ACK;
      ST_XOR1: state_next = ST_XOR2;
      ST_XOR2: state_next = ST_ACK;
`else
      ST_EXEC: state_next = ST_ACK;
`endif
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
      op_reg    <= OP_NOP;
      data_reg  <= '0;
      last_reg  <= IW'(N - 1);
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (win_valid) begin
            gnt_reg  <= win_onehot;
            op_reg   <= op_sel[win_idx];
            data_reg <= wdata_sel[win_idx];
            last_reg <= win_idx;
          end
        end
        ST_EXEC: begin
          case (op_reg)
            OP_LOAD_A: a_q <= data_reg;
            OP_LOAD_B: b_q <= data_reg;
`ifdef SWAP_XOR_EN
            OP_SWAP:   a_q <= a_q ^ b_q;
`else
            OP_SWAP: begin
              a_q <= b_q;
              b_q <= a_q;
            end
`endif
            default: ;
          endcase
        end
`ifdef SWAP_XOR_EN
        ST_XOR1: b_q <= a_q ^ b_q;
        ST_XOR2: a_q <= a_q ^ b_q;
`endif
        // Grant is held through ACK and dropped on the way back to IDLE
        ST_ACK:  gnt_reg <= '0;
        default: ;
      endcase
    end
  end

  assign gnt  = gnt_reg;
  assign ack  = (state_reg == ST_ACK);
  assign busy = (state_reg != ST_IDLE);

endmodule
